// File: rtl/pong_game_sequencer.sv
// Pong match controller: per-frame paddle/ball/check sequencing, match FSM and scores.
// Optional PONG_OVERRUN_CNT_EN adds io_overrun, a saturating count of dropped frame ticks.
module pong_game_sequencer #(
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_frame_tick,
  input  logic               io_start,
  input  logic               io_check_done,
  input  logic               io_miss_left,
  input  logic               io_miss_right,
  output logic               io_paddle_upd,
  output logic               io_ball_upd,
  output logic               io_check_req,
  output logic               io_ball_reset,
  output logic               io_serve_dir,
  output logic [SCORE_W-1:0] io_score_left,
  output logic [SCORE_W-1:0] io_score_right,
  output logic [2:0]         io_state,
  output logic               io_winner_left
`ifdef PONG_OVERRUN_CNT_EN
  ,output logic [7:0]        io_overrun
`endif
);

  localparam int CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } match_e;

  typedef enum logic [1:0] {
    SQ_WAIT  = 2'd0,
    SQ_PAD   = 2'd1,
    SQ_BALL  = 2'd2,
    SQ_CHECK = 2'd3
  } seq_e;

  match_e             state_q, state_d;
  seq_e               seq_q, seq_d;
  logic               seq_play_q, seq_play_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [SCORE_W-1:0] score_left_q, score_left_d;
  logic [SCORE_W-1:0] score_right_q, score_right_d;
  logic               serve_dir_q, serve_dir_d;
  logic               winner_left_q, winner_left_d;
  logic               ball_reset_q, ball_reset_d;
  logic               paddle_upd_q, paddle_upd_d;
  logic               ball_upd_q, ball_upd_d;
  logic               check_req_q, check_req_d;

  logic tick_accept;
  logic check_fire;

  assign tick_accept = io_frame_tick && (seq_q == SQ_WAIT);
  assign check_fire  = io_check_done && (seq_q == SQ_CHECK);

  always_comb begin
    seq_d         = seq_q;
    seq_play_d    = seq_play_q;
    paddle_upd_d  = 1'b0;
    ball_upd_d    = 1'b0;
    check_req_d   = check_req_q;
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    score_left_d  = score_left_q;
    score_right_d = score_right_q;
    serve_dir_d   = serve_dir_q;
    winner_left_d = winner_left_q;

    // The ball step is decided by the match state when the tick was accepted.
    case (seq_q)
      SQ_WAIT: begin
        if (tick_accept && (state_q == ST_SERVE || state_q == ST_PLAY || state_q == ST_POINT)) begin
          seq_d        = SQ_PAD;
          paddle_upd_d = 1'b1;
          seq_play_d   = (state_q == ST_PLAY);
        end else begin
          seq_d = SQ_WAIT;
        end
      end
      SQ_PAD: begin
        if (seq_play_q) begin
          seq_d      = SQ_BALL;
          ball_upd_d = 1'b1;
        end else begin
          seq_d = SQ_WAIT;
        end
      end
      SQ_BALL: begin
        seq_d       = SQ_CHECK;
        check_req_d = 1'b1;
      end
      SQ_CHECK: begin
        if (io_check_done) begin
          seq_d       = SQ_WAIT;
          check_req_d = 1'b0;
        end else begin
          seq_d = SQ_CHECK;
        end
      end
      default: begin
        seq_d       = SQ_WAIT;
        check_req_d = 1'b0;
      end
    endcase

    case (state_q)
      ST_IDLE: begin
        if (io_start) begin
          state_d       = ST_SERVE;
          score_left_d  = '0;
          score_right_d = '0;
          frame_cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVE: begin
        if (tick_accept && frame_cnt_q == SERVE_LAST) begin
          state_d     = ST_PLAY;
          frame_cnt_d = '0;
        end else if (tick_accept) begin
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end else begin
          frame_cnt_d = frame_cnt_q;
        end
      end
      ST_PLAY: begin
        frame_cnt_d = '0;
        if (check_fire && io_miss_left && io_miss_right) begin
          state_d = ST_SERVE;
        end else if (check_fire && io_miss_left) begin
          state_d       = ST_POINT;
          score_right_d = score_right_q + SCORE_W'(1);
          serve_dir_d   = 1'b0;
        end else if (check_fire && io_miss_right) begin
          state_d      = ST_POINT;
          score_left_d = score_left_q + SCORE_W'(1);
          serve_dir_d  = 1'b1;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_POINT: begin
        if (tick_accept && frame_cnt_q == POINT_LAST) begin
          frame_cnt_d = '0;
          if (score_left_q == WIN || score_right_q == WIN) begin
            state_d       = ST_OVER;
            winner_left_d = (score_left_q == WIN);
          end else begin
            state_d = ST_SERVE;
          end
        end else if (tick_accept) begin
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end else begin
          frame_cnt_d = frame_cnt_q;
        end
      end
      ST_OVER: begin
        if (io_start) begin
          state_d       = ST_SERVE;
          score_left_d  = '0;
          score_right_d = '0;
          serve_dir_d   = 1'b1;
          frame_cnt_d   = '0;
        end else begin
          state_d = ST_OVER;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        frame_cnt_d = '0;
      end
    endcase

    ball_reset_d = !(state_d == ST_PLAY || state_d == ST_POINT);
  end

`ifdef PONG_OVERRUN_CNT_EN
  logic [7:0] overrun_q, overrun_d;
  logic       tick_drop;

  assign tick_drop = io_frame_tick && (seq_q != SQ_WAIT);

  always_comb begin
    overrun_d = overrun_q;
    if ((state_q == ST_IDLE || state_q == ST_OVER) && state_d == ST_SERVE) begin
      overrun_d = 8'd0;
    end else if (tick_drop && overrun_q != 8'hFF) begin
      overrun_d = overrun_q + 8'd1;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      overrun_q <= 8'd0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign io_overrun = overrun_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      seq_q         <= SQ_WAIT;
      seq_play_q    <= 1'b0;
      frame_cnt_q   <= '0;
      score_left_q  <= '0;
      score_right_q <= '0;
      serve_dir_q   <= 1'b1;
      winner_left_q <= 1'b0;
      ball_reset_q  <= 1'b1;
      paddle_upd_q  <= 1'b0;
      ball_upd_q    <= 1'b0;
      check_req_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      seq_q         <= seq_d;
      seq_play_q    <= seq_play_d;
      frame_cnt_q   <= frame_cnt_d;
      score_left_q  <= score_left_d;
      score_right_q <= score_right_d;
      serve_dir_q   <= serve_dir_d;
      winner_left_q <= winner_left_d;
      ball_reset_q  <= ball_reset_d;
      paddle_upd_q  <= paddle_upd_d;
      ball_upd_q    <= ball_upd_d;
      check_req_q   <= check_req_d;
    end
  end

  assign io_paddle_upd  = paddle_upd_q;
  assign io_ball_upd    = ball_upd_q;
  assign io_check_req   = check_req_q;
  assign io_ball_reset  = ball_reset_q;
  assign io_serve_dir   = serve_dir_q;
  assign io_score_left  = score_left_q;
  assign io_score_right = score_right_q;
  assign io_state       = state_q;
  assign io_winner_left = winner_left_q;

endmodule
